stream_tx_scheduler: RTL and testbench

//   Round-robin scheduler sharing one byte-wide Bluetooth/UART transmit path between the

---
 rtl/stream_tx_scheduler_pkg.sv | 32 +++
 rtl/stream_tx_scheduler_rr_picker.sv | 43 ++++
 rtl/stream_tx_scheduler.sv | 176 +++++++++++++++++
 tb/tb_stream_tx_scheduler.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_tx_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_tx_scheduler_pkg
// Purpose  : Shared definitions for the stream transmit scheduler: default
//            widths, header tag, FSM state encoding and the frame byte-count
//            helper.
// Revision : 1.0  initial release
// ============================================================================
package stream_tx_scheduler_pkg;

    // Default geometry of the ion capture streams
    localparam int c_def_n_streams = 8;
    localparam int c_def_frame_w   = 110;
    localparam int c_def_sel_w     = 3;

    // Upper bits of the header byte; the granted stream index is OR-ed into
    // the low bits.
    localparam logic [7:0] c_header_tag = 8'hA0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_PAYLOAD = 2'd2
    } state_t;

    // Number of payload bytes needed to carry one frame (rounded up)
    function automatic int nbytes(input int frame_w);
        return (frame_w + 7) / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_tx_scheduler_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : stream_tx_scheduler_rr_picker
// Purpose  : Combinational round-robin picker. Returns the first asserted
//            request found when searching ptr, ptr+1, ... modulo N_STREAMS.
// Ports    : req  - per-stream request flags
//            ptr  - highest-priority stream index
//            any  - at least one request asserted
//            idx  - index of the chosen request (0 when none)
// Revision : 1.0  initial release
// ============================================================================
module stream_tx_scheduler_rr_picker
    import stream_tx_scheduler_pkg::*;
#(
    parameter int N_STREAMS = c_def_n_streams,
    parameter int SEL_W     = c_def_sel_w
) (
    input  logic [N_STREAMS-1:0] req,
    input  logic [SEL_W-1:0]     ptr,
    output logic                 any,
    output logic [SEL_W-1:0]     idx
);

    logic [SEL_W-1:0] w_cand;

    // Walk from the farthest offset down to offset 0 so the nearest request
    // to ptr is the last one written and therefore wins. N_STREAMS is a
    // power of two, so SEL_W-bit addition wraps modulo N_STREAMS for free.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = N_STREAMS - 1; i >= 0; i--) begin
            w_cand = ptr + SEL_W'(i);
            if (req[w_cand]) begin
                any = 1'b1;
                idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stream_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : stream_tx_scheduler
// Purpose  : Round-robin scheduler sharing one byte-wide transmit path among
//            the sensor streams. Grants one ready stream at a time, latches
//            its frame and sends a header byte followed by the frame bytes,
//            most-significant byte first.
// Ports    : clock/reset          - clock, synchronous active-high reset
//            enable               - allow new grants
//            ready/frames         - per-stream flags and packed frames
//            ack                  - one-cycle grant pulse, one-hot
//            sel/busy             - granted stream index, frame in progress
//            tx_byte/tx_valid/tx_ready - byte stream to the transmitter
//            frame_count          - frames fully sent (wrapping)
// Revision : 1.0  initial release
// ============================================================================
module stream_tx_scheduler
    import stream_tx_scheduler_pkg::*;
#(
    parameter int N_STREAMS = c_def_n_streams,
    parameter int FRAME_W   = c_def_frame_w,
    parameter int SEL_W     = c_def_sel_w
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [N_STREAMS-1:0]         ready,
    input  logic [N_STREAMS*FRAME_W-1:0] frames,
    output logic [N_STREAMS-1:0]         ack,
    output logic [SEL_W-1:0]             sel,
    output logic                         busy,
    output logic [7:0]                   tx_byte,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic [15:0]                  frame_count
);

    localparam int c_nbytes  = nbytes(FRAME_W);
    localparam int c_shift_w = c_nbytes * 8;
    localparam int c_cnt_w   = $clog2(c_nbytes + 1);

    // ---------------------------------------------------------------- state
    state_t                 r_state, w_state_nxt;
    logic [SEL_W-1:0]       r_ptr, w_ptr_nxt;
    logic [SEL_W-1:0]       r_sel, w_sel_nxt;
    logic [N_STREAMS-1:0]   r_ack, w_ack_nxt;
    logic                   r_busy, w_busy_nxt;
    logic [7:0]             r_tx_byte, w_tx_byte_nxt;
    logic                   r_tx_valid, w_tx_valid_nxt;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt;
    logic [c_shift_w-1:0]   r_shift, w_shift_nxt;
    logic [15:0]            r_frame_count, w_frame_count_nxt;

    // --------------------------------------------------------- frame unpack
    logic [FRAME_W-1:0] w_frame_arr [N_STREAMS];

    for (genvar k = 0; k < N_STREAMS; k++) begin : g_unpack
        assign w_frame_arr[k] = frames[k*FRAME_W +: FRAME_W];
    end

    // --------------------------------------------------------------- picker
    logic             w_any;
    logic [SEL_W-1:0] w_idx;

    stream_tx_scheduler_rr_picker #(
        .N_STREAMS (N_STREAMS),
        .SEL_W     (SEL_W)
    ) u_picker (
        .req (ready),
        .ptr (r_ptr),
        .any (w_any),
        .idx (w_idx)
    );

    logic                 w_accept;
    logic [c_shift_w-1:0] w_shifted;

    assign w_accept  = r_tx_valid & tx_ready;
    assign w_shifted = r_shift << 8;

    // ------------------------------------------------ next-state / outputs
    always_comb begin
        w_state_nxt       = r_state;
        w_ptr_nxt         = r_ptr;
        w_sel_nxt         = r_sel;
        w_ack_nxt         = '0;
        w_busy_nxt        = r_busy;
        w_tx_byte_nxt     = r_tx_byte;
        w_tx_valid_nxt    = r_tx_valid;
        w_cnt_nxt         = r_cnt;
        w_shift_nxt       = r_shift;
        w_frame_count_nxt = r_frame_count;

        case (r_state)
            ST_IDLE: begin
                if (enable && w_any) begin
                    // Frame is zero-padded at the MSB end up to whole bytes
                    w_shift_nxt    = c_shift_w'(w_frame_arr[w_idx]);
                    w_sel_nxt      = w_idx;
                    w_ack_nxt      = N_STREAMS'(1) << w_idx;
                    w_busy_nxt     = 1'b1;
                    w_tx_valid_nxt = 1'b1;
                    w_tx_byte_nxt  = c_header_tag | 8'(w_idx);
                    w_state_nxt    = ST_HEADER;
                end
            end

            ST_HEADER: begin
                if (w_accept) begin
                    w_tx_byte_nxt = r_shift[c_shift_w-1 -: 8];
                    w_cnt_nxt     = '0;
                    w_state_nxt   = ST_PAYLOAD;
                end
            end

            ST_PAYLOAD: begin
                if (w_accept) begin
                    if (r_cnt == c_cnt_w'(c_nbytes - 1)) begin
                        w_tx_valid_nxt    = 1'b0;
                        w_busy_nxt        = 1'b0;
                        w_frame_count_nxt = r_frame_count + 16'd1;
                        // Granted stream drops to lowest priority next round
                        w_ptr_nxt         = r_sel + 1'b1;
                        w_state_nxt       = ST_IDLE;
                    end else begin
                        w_shift_nxt   = w_shifted;
                        w_tx_byte_nxt = w_shifted[c_shift_w-1 -: 8];
                        w_cnt_nxt     = r_cnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt    = ST_IDLE;
                w_busy_nxt     = 1'b0;
                w_tx_valid_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_sel         <= '0;
            r_ack         <= '0;
            r_busy        <= 1'b0;
            r_tx_byte     <= '0;
            r_tx_valid    <= 1'b0;
            r_cnt         <= '0;
            r_shift       <= '0;
            r_frame_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_ptr         <= w_ptr_nxt;
            r_sel         <= w_sel_nxt;
            r_ack         <= w_ack_nxt;
            r_busy        <= w_busy_nxt;
            r_tx_byte     <= w_tx_byte_nxt;
            r_tx_valid    <= w_tx_valid_nxt;
            r_cnt         <= w_cnt_nxt;
            r_shift       <= w_shift_nxt;
            r_frame_count <= w_frame_count_nxt;
        end
    end

    assign ack         = r_ack;
    assign sel         = r_sel;
    assign busy        = r_busy;
    assign tx_byte     = r_tx_byte;
    assign tx_valid    = r_tx_valid;
    assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_stream_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_tx_scheduler
// Purpose  : Directed self-checking bench for stream_tx_scheduler: reset,
//            single-stream frame, backpressure, reset mid-frame, round-robin
//            fairness and enable drop.
// Revision : 1.0  initial release
// ============================================================================
module tb_stream_tx_scheduler;

    localparam int N_STREAMS = 8;
    localparam int FRAME_W   = 110;
    localparam int SEL_W     = 3;

    logic                         clock;
    logic                         reset;
    logic                         enable;
    logic [N_STREAMS-1:0]         ready;
    logic [N_STREAMS*FRAME_W-1:0] frames;
    logic [N_STREAMS-1:0]         ack;
    logic [SEL_W-1:0]             sel;
    logic                         busy;
    logic [7:0]                   tx_byte;
    logic                         tx_valid;
    logic                         tx_ready;
    logic [15:0]                  frame_count;

    stream_tx_scheduler #(
        .N_STREAMS (N_STREAMS),
        .FRAME_W   (FRAME_W),
        .SEL_W     (SEL_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .ready       (ready),
        .frames      (frames),
        .ack         (ack),
        .sel         (sel),
        .busy        (busy),
        .tx_byte     (tx_byte),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .frame_count (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed traffic, captured on the falling edge
    logic [7:0]           byte_q [$];
    logic [7:0]           hdr_q  [$];
    logic [N_STREAMS-1:0] ack_q  [$];
    int                   tx_cycles = 0;
    int                   hold_err  = 0;
    bit                   prev_stall = 1'b0;
    logic [7:0]           prev_byte  = 8'h00;

    always @(negedge clock) begin
        if (tx_valid) tx_cycles++;
        if (tx_valid && tx_ready) byte_q.push_back(tx_byte);
        if (ack != '0) begin
            ack_q.push_back(ack);
            hdr_q.push_back(tx_byte);
        end
        if (prev_stall && !reset && (!tx_valid || tx_byte != prev_byte)) hold_err++;
        prev_stall = tx_valid && !tx_ready && !reset;
        prev_byte  = tx_byte;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_logs();
        byte_q.delete();
        hdr_q.delete();
        ack_q.delete();
        tx_cycles = 0;
        hold_err  = 0;
    endtask

    // Wait for the current frame to finish; optionally toggle tx_ready each cycle
    task automatic wait_idle(input string tag, input bit toggle);
        int n = 0;
        while (busy && n < 300) begin
            tick();
            if (toggle) tx_ready = ~tx_ready;
            n++;
        end
        check_eq(tag, {31'd0, busy}, 32'd0);
    endtask

    // Stream 3 carries 110'h1: header A3, thirteen 00 bytes, then 01
    task automatic check_frame3(input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        check_eq({tag, "_nbytes"}, byte_q.size(), 32'd15);
        for (int i = 0; i < 15; i++) begin
            got = (i < byte_q.size()) ? byte_q[i] : 8'hEE;
            exp = (i == 0) ? 8'hA3 : (i == 14) ? 8'h01 : 8'h00;
            check_eq($sformatf("%s_byte%0d", tag, i), {24'd0, got}, {24'd0, exp});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b1;
        ready    = 8'hFF;
        tx_ready = 1'b1;
        frames   = '0;
        frames[3*FRAME_W +: FRAME_W] = 110'h1;

        // ---------------- reset held 3 cycles with all streams ready
        tick(); tick(); tick();
        check_eq("rst_ack",      {24'd0, ack},       32'h0);
        check_eq("rst_tx_valid", {31'd0, tx_valid},  32'h0);
        check_eq("rst_busy",     {31'd0, busy},      32'h0);
        check_eq("rst_sel",      {29'd0, sel},       32'h0);
        check_eq("rst_fcount",   {16'd0, frame_count}, 32'h0);
        ready = 8'h00;
        reset = 1'b0;
        tick();

        // ---------------- single stream, no backpressure
        clear_logs();
        ready = 8'h08;
        tick();
        check_eq("ss_ack",      {24'd0, ack},      32'h08);
        check_eq("ss_tx_valid", {31'd0, tx_valid}, 32'h1);
        check_eq("ss_hdr",      {24'd0, tx_byte},  32'hA3);
        check_eq("ss_busy",     {31'd0, busy},     32'h1);
        ready = 8'h00;
        tick();
        check_eq("ss_ack_pulse", {24'd0, ack}, 32'h0);
        wait_idle("ss_done", 1'b0);
        check_frame3("ss");
        check_eq("ss_tx_cycles", tx_cycles, 32'd15);
        check_eq("ss_nacks",     ack_q.size(), 32'd1);
        check_eq("ss_fcount",    {16'd0, frame_count}, 32'd1);
        check_eq("ss_sel",       {29'd0, sel}, 32'd3);

        // ---------------- backpressure: tx_ready alternating, low first
        tick();
        clear_logs();
        ready = 8'h08;
        tick();
        check_eq("bp_ack", {24'd0, ack}, 32'h08);
        ready    = 8'h00;
        tx_ready = 1'b0;
        wait_idle("bp_done", 1'b1);
        tx_ready = 1'b1;
        check_frame3("bp");
        check_eq("bp_tx_cycles", tx_cycles, 32'd30);
        check_eq("bp_hold_err",  hold_err,  32'd0);
        check_eq("bp_fcount",    {16'd0, frame_count}, 32'd2);

        // ---------------- reset after the 5th payload byte
        tick();
        clear_logs();
        ready = 8'h08;
        tick();
        ready = 8'h00;
        begin
            int n = 0;
            while (byte_q.size() < 6 && n < 100) begin
                tick();
                n++;
            end
        end
        check_eq("mr_bytes_before_rst", byte_q.size(), 32'd6);
        reset = 1'b1;
        tick();
        check_eq("mr_tx_valid", {31'd0, tx_valid}, 32'h0);
        check_eq("mr_busy",     {31'd0, busy},     32'h0);
        check_eq("mr_fcount",   {16'd0, frame_count}, 32'h0);
        // Pointer was 4 before reset: streams 3 and 7 ready shows it is back at 0
        reset = 1'b0;
        ready = 8'h88;
        tick();
        check_eq("mr_restart_ack", {24'd0, ack},     32'h08);
        check_eq("mr_restart_hdr", {24'd0, tx_byte}, 32'hA3);
        ready = 8'h00;
        wait_idle("mr_done", 1'b0);
        check_eq("mr_fcount_after", {16'd0, frame_count}, 32'd1);

        // ---------------- fairness from a fresh reset, all streams ready
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        clear_logs();
        ready  = 8'hFF;
        enable = 1'b1;
        begin
            int n = 0;
            while (ack_q.size() < 9 && n < 400) begin
                tick();
                n++;
            end
        end
        check_eq("fr_nacks", ack_q.size(), 32'd9);
        // Drop enable while the 9th frame is in PAYLOAD
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] h;
            logic [7:0] a;
            h = (i < hdr_q.size()) ? hdr_q[i] : 8'hEE;
            a = (i < ack_q.size()) ? ack_q[i] : 8'hEE;
            check_eq($sformatf("fr_hdr%0d", i), {24'd0, h}, 32'hA0 + (i % 8));
            check_eq($sformatf("fr_ack%0d", i), {24'd0, a}, 32'(1) << (i % 8));
        end

        // ---------------- enable drop: frame finishes, no further grants
        wait_idle("en_done", 1'b0);
        check_eq("en_fcount", {16'd0, frame_count}, 32'd9);
        for (int i = 0; i < 20; i++) tick();
        check_eq("en_no_ack", ack_q.size(), 32'd9);
        check_eq("en_busy",   {31'd0, busy}, 32'h0);
        enable = 1'b1;
        tick();
        check_eq("en_resume_ack", {24'd0, ack},     32'h02);
        check_eq("en_resume_hdr", {24'd0, tx_byte}, 32'hA1);
        ready = 8'h00;
        wait_idle("en_resume_done", 1'b0);
        check_eq("en_fcount_after", {16'd0, frame_count}, 32'd10);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
